bcd_countdown_core: RTL and testbench

//  Parametrised N-digit BCD countdown timer core with preset, run/pause control, per-digit edit and optional auto-reload.

---
 rtl/bcd_countdown_core.sv | 219 +++++++++++++++++++++
 tb/tb_bcd_countdown_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_core.sv
// N-digit BCD countdown timer core: preset, run/pause, per-digit edit,
// optional auto-reload. Counts natively in BCD for a 7-segment driver.
//
// Ports:
//   CLK, CLR       clock; asynchronous active-high reset
//   CE             count tick, one BCD decrement per high cycle in RUN
//   START, STOP    run/resume and pause/abort pulses
//   LOAD,LOAD_VAL  capture a BCD value (digits >9 saturate to 9)
//   INC, DEC       +/-1 on digit DIG_SEL while idle, no carry
//   DIG_SEL        digit index for INC/DEC
//   Q              current count, digit 0 in bits [3:0]
//   RUNNING        high in RUN
//   DONE           one-cycle pulse when the count reaches zero
//   EXPIRED        high in EXPIRED
module bcd_countdown_core #(
  parameter int DIGITS = 4,
  parameter bit RELOAD = 1'b0,
  parameter logic [4*DIGITS-1:0] PRESET = '0,
  parameter int SELW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  input  logic                  INC,
  input  logic                  DEC,
  input  logic [SELW-1:0]       DIG_SEL,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  RUNNING,
  output logic                  DONE,
  output logic                  EXPIRED
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXP
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] pre;
  logic [W-1:0] pre_nx;
  logic [W-1:0] q_nx;
  logic         done_nx;

  logic         c_load;
  logic         c_stop;
  logic         c_start;
  logic         c_edit;
  logic         c_tick;
  logic         q_zero;
  logic         q_one;
  logic         sel_ok;
  logic         pre_zero;

  function automatic logic [W-1:0] bcd_sat(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // Ripple borrow: zeros below the first nonzero
  // digit become 9, that digit drops by one.
  function automatic logic [W-1:0] bcd_dec(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Single-digit wrap, neighbours untouched.
  function automatic logic [W-1:0] bcd_edit(
    input logic [W-1:0]  v,
    input logic          up,
    input logic [SELW-1:0] sel
  );
    logic [W-1:0] r;
    logic [3:0]   d;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(sel)) begin
        d = v[4*i +: 4];
        if (up) begin
          r[4*i +: 4] = (d >= 4'd9) ? 4'd0 : d + 4'd1;
        end else begin
          r[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign q_zero   = (Q == '0);
  assign q_one    = (Q == ONE);
  assign pre_zero = (pre == '0);
  assign sel_ok   = (int'(DIG_SEL) < DIGITS);

  // One-hot command after priority masking;
  // the highest asserted input wins, the rest drop.
  always_comb begin
    c_load  = LOAD;
    c_stop  = STOP & ~LOAD;
    c_start = START & ~STOP & ~LOAD;
    c_edit  = (INC | DEC) & ~START & ~STOP & ~LOAD;
    c_tick  = CE & ~INC & ~DEC & ~START
            & ~STOP & ~LOAD;
  end

  always_comb begin
    state_nx = state;
    q_nx     = Q;
    pre_nx   = pre;
    done_nx  = 1'b0;
    unique case (1'b1)
      c_load: begin
        pre_nx   = bcd_sat(LOAD_VAL);
        q_nx     = bcd_sat(LOAD_VAL);
        state_nx = S_IDLE;
      end
      c_stop: begin
        case (state)
          S_RUN:   state_nx = S_PAUSE;
          S_PAUSE: state_nx = S_IDLE;
          S_EXP: begin
            state_nx = S_IDLE;
            q_nx     = pre;
          end
          default: state_nx = state;
        endcase
      end
      c_start: begin
        case (state)
          S_IDLE: begin
            if (!q_zero) begin
              state_nx = S_RUN;
            end
          end
          S_PAUSE: state_nx = S_RUN;
          S_EXP: begin
            state_nx = S_IDLE;
            q_nx     = pre;
          end
          default: state_nx = state;
        endcase
      end
      c_edit: begin
        if (state == S_IDLE && (INC ^ DEC)
            && sel_ok) begin
          q_nx   = bcd_edit(Q, INC, DIG_SEL);
          pre_nx = bcd_edit(pre, INC, DIG_SEL);
        end
      end
      c_tick: begin
        if (state == S_RUN) begin
          if (q_one) begin
            done_nx = 1'b1;
            if (RELOAD && !pre_zero) begin
              q_nx = pre;
            end else begin
              q_nx     = '0;
              state_nx = S_EXP;
            end
          end else begin
            q_nx = bcd_dec(Q);
          end
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
      Q     <= PRESET;
      pre   <= PRESET;
      DONE  <= 1'b0;
    end else begin
      state <= state_nx;
      Q     <= q_nx;
      pre   <= pre_nx;
      DONE  <= done_nx;
    end
  end

  assign RUNNING = (state == S_RUN);
  assign EXPIRED = (state == S_EXP);

endmodule

// File: tb/tb_bcd_countdown_core.sv
// Bench for bcd_countdown_core: two instances (stop-at-zero and
// auto-reload) against an integer-valued reference model.
module tb_bcd_countdown_core;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        CE = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] LOAD_VAL = '0;
  logic        INC = 1'b0;
  logic        DEC = 1'b0;
  logic [1:0]  DIG_SEL = '0;

  logic [15:0] Q0, Q1;
  logic        R0, R1, D0, D1, E0, E1;

  int vecs  = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LOAD  = 6'b100000;
  localparam logic [5:0] C_STOP  = 6'b010000;
  localparam logic [5:0] C_START = 6'b001000;
  localparam logic [5:0] C_INC   = 6'b000100;
  localparam logic [5:0] C_DEC   = 6'b000010;
  localparam logic [5:0] C_CE    = 6'b000001;

  bcd_countdown_core #(
    .DIGITS(4), .RELOAD(1'b0), .PRESET(16'h0025)
  ) dut0 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START),
    .STOP(STOP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .INC(INC), .DEC(DEC), .DIG_SEL(DIG_SEL),
    .Q(Q0), .RUNNING(R0), .DONE(D0), .EXPIRED(E0)
  );

  bcd_countdown_core #(
    .DIGITS(4), .RELOAD(1'b1), .PRESET(16'h0000)
  ) dut1 (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START),
    .STOP(STOP), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .INC(INC), .DEC(DEC), .DIG_SEL(DIG_SEL),
    .Q(Q1), .RUNNING(R1), .DONE(D1), .EXPIRED(E1)
  );

  always #5 CLK = ~CLK;

  // Reference model: count held as a plain integer.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP  = 3;

  int mq[2];
  int mp[2];
  int ms[2];
  bit md[2];

  function automatic int pow10(input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return p;
  endfunction

  function automatic int load_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int x);
    logic [15:0] r = '0;
    int y = x;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic int edit(input int x, input int i,
                              input bit up);
    int p  = pow10(i);
    int d  = (x / p) % 10;
    int nd = up ? (d + 1) % 10 : (d + 9) % 10;
    return x + (nd - d) * p;
  endfunction

  task automatic step(input int k, input bit rl);
    md[k] = 1'b0;
    if (LOAD) begin
      mp[k] = load_int(LOAD_VAL);
      mq[k] = mp[k];
      ms[k] = M_IDLE;
    end else if (STOP) begin
      if (ms[k] == M_RUN) ms[k] = M_PAUSE;
      else if (ms[k] == M_PAUSE) ms[k] = M_IDLE;
      else if (ms[k] == M_EXP) begin
        ms[k] = M_IDLE;
        mq[k] = mp[k];
      end
    end else if (START) begin
      if (ms[k] == M_IDLE && mq[k] != 0) ms[k] = M_RUN;
      else if (ms[k] == M_PAUSE) ms[k] = M_RUN;
      else if (ms[k] == M_EXP) begin
        ms[k] = M_IDLE;
        mq[k] = mp[k];
      end
    end else if (INC || DEC) begin
      if (ms[k] == M_IDLE && INC != DEC) begin
        mq[k] = edit(mq[k], int'(DIG_SEL), INC);
        mp[k] = edit(mp[k], int'(DIG_SEL), INC);
      end
    end else if (CE && ms[k] == M_RUN) begin
      mq[k] = mq[k] - 1;
      if (mq[k] == 0) begin
        md[k] = 1'b1;
        if (rl && mp[k] != 0) mq[k] = mp[k];
        else ms[k] = M_EXP;
      end
    end
  endtask

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      mq[0] = 25; mp[0] = 25; ms[0] = M_IDLE; md[0] = 0;
      mq[1] = 0;  mp[1] = 0;  ms[1] = M_IDLE; md[1] = 0;
    end else begin
      step(0, 1'b0);
      step(1, 1'b1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en && !CLR) begin
      chk("m_q0", 32'(Q0), 32'(to_bcd(mq[0])));
      chk("m_run0", 32'(R0), 32'(ms[0] == M_RUN));
      chk("m_done0", 32'(D0), 32'(md[0]));
      chk("m_exp0", 32'(E0), 32'(ms[0] == M_EXP));
      chk("m_q1", 32'(Q1), 32'(to_bcd(mq[1])));
      chk("m_run1", 32'(R1), 32'(ms[1] == M_RUN));
      chk("m_done1", 32'(D1), 32'(md[1]));
      chk("m_exp1", 32'(E1), 32'(ms[1] == M_EXP));
    end
  end

  task automatic apply(input logic [5:0] c,
                       input logic [15:0] lv = 16'h0,
                       input logic [1:0] sel = 2'd0);
    {LOAD, STOP, START, INC, DEC, CE} = c;
    LOAD_VAL = lv;
    DIG_SEL  = sel;
    @(negedge CLK);
    {LOAD, STOP, START, INC, DEC, CE} = C_NONE;
  endtask

  logic [15:0] e3[7] = '{16'h0002, 16'h0001, 16'h0003,
                         16'h0002, 16'h0001, 16'h0003,
                         16'h0002};
  logic        d3[7] = '{1'b0, 1'b0, 1'b1, 1'b0,
                         1'b0, 1'b1, 1'b0};

  initial begin
    #2 CLR = 1'b1;
    @(negedge CLK);
    chk("rst_q0", 32'(Q0), 32'h0025);
    chk("rst_q1", 32'(Q1), 32'h0000);
    chk("rst_flags0", 32'({R0, D0, E0}), 32'd0);
    CLR = 1'b0;
    chk_en = 1'b1;

    // countdown from 12 to expiry
    apply(C_LOAD, 16'h0012);
    apply(C_START);
    chk("t1_run", 32'(R0), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      apply(C_CE);
      if (i == 11) begin
        chk("t1_q11", 32'(Q0), 32'h0001);
        chk("t1_nodone", 32'(D0), 32'd0);
      end
    end
    chk("t1_q0", 32'(Q0), 32'h0000);
    chk("t1_done", 32'(D0), 32'd1);
    chk("t1_exp", 32'(E0), 32'd1);
    chk("t1_run0", 32'(R0), 32'd0);
    apply(C_CE);
    chk("t1_done1cyc", 32'(D0), 32'd0);
    chk("t1_hold", 32'(Q0), 32'h0000);
    apply(C_START);
    chk("t1_rearm", 32'(Q0), 32'h0012);
    chk("t1_idle", 32'(E0), 32'd0);

    // borrow chains
    apply(C_LOAD, 16'h1000);
    apply(C_START);
    apply(C_CE);
    chk("t2_999", 32'(Q0), 32'h0999);
    apply(C_LOAD, 16'h0100);
    apply(C_START);
    apply(C_CE);
    chk("t2_99", 32'(Q0), 32'h0099);

    // auto-reload instance
    apply(C_LOAD, 16'h0003);
    apply(C_START);
    for (int i = 0; i < 7; i++) begin
      apply(C_CE);
      chk("t3_q", 32'(Q1), 32'(e3[i]));
      chk("t3_done", 32'(D1), 32'(d3[i]));
      chk("t3_run", 32'(R1), 32'd1);
    end

    // pause / resume / abort
    apply(C_LOAD, 16'h0050);
    apply(C_START);
    apply(C_STOP);
    for (int i = 0; i < 5; i++) apply(C_CE);
    chk("t4_hold", 32'(Q0), 32'h0050);
    chk("t4_pause", 32'(R0), 32'd0);
    apply(C_INC);
    chk("t4_noinc", 32'(Q0), 32'h0050);
    apply(C_START);
    apply(C_CE);
    chk("t4_49", 32'(Q0), 32'h0049);
    apply(C_STOP);
    apply(C_STOP);
    chk("t4_idle_q", 32'(Q0), 32'h0049);
    chk("t4_idle_f", 32'({R0, E0}), 32'd0);
    apply(C_LOAD, 16'h0000);
    apply(C_START);
    chk("t4_zero_start", 32'(R0), 32'd0);

    // priority, saturation, digit edits
    apply(C_LOAD | C_START, 16'h00A7);
    chk("t5_sat", 32'(Q0), 32'h0097);
    chk("t5_idle", 32'(R0), 32'd0);
    apply(C_LOAD, 16'h0009);
    apply(C_INC, 16'h0, 2'd0);
    chk("t5_wrap", 32'(Q0), 32'h0000);
    apply(C_DEC, 16'h0, 2'd3);
    chk("t5_dec3", 32'(Q0), 32'h9000);
    apply(C_INC | C_DEC, 16'h0, 2'd3);
    chk("t5_both", 32'(Q0), 32'h9000);
    apply(C_START);
    apply(C_CE);
    chk("t5_8999", 32'(Q0), 32'h8999);
    apply(C_STOP | C_CE);
    apply(C_STOP);

    // asynchronous clear mid-run
    apply(C_LOAD, 16'h0040);
    apply(C_START);
    apply(C_CE);
    chk("t6_pre", 32'(Q0), 32'h0039);
    CE = 1'b1;
    #2 CLR = 1'b1;
    #1;
    chk("t6_q0", 32'(Q0), 32'h0025);
    chk("t6_q1", 32'(Q1), 32'h0000);
    chk("t6_flags", 32'({R0, D0, E0, R1, D1, E1}), 32'd0);
    @(negedge CLK);
    CE = 1'b0;
    CLR = 1'b0;
    apply(C_NONE);
    chk("t6_after", 32'(Q0), 32'h0025);
    chk("t6_nodone", 32'(D0), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end

endmodule
